// File: rtl/instr_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// instr_sequencer_pkg
// Shared constants for the instruction sequencer:
//   - FSM state encoding (IDLE, FETCH, ISSUE, DONE)
//   - opcode field position inside an instruction word
//   - default HALT opcode and NOP word
// -----------------------------------------------------------------------------
package instr_sequencer_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_FETCH = 2'd1;
    localparam logic [STATE_W-1:0] ST_ISSUE = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

    localparam int OPC_MSB = 19;
    localparam int OPC_LSB = 16;

    localparam logic [3:0]  HALT_OPC_DEF  = 4'hF;
    localparam logic [19:0] NOP_INSTR_DEF = 20'h00000;

endpackage

// File: rtl/instr_sequencer_if.sv
// -----------------------------------------------------------------------------
// instr_sequencer_if
// Bundles the host-side program/control signals and the CPU-side instruction
// outputs of the sequencer.
//   slave  : the sequencer (consumes prog_*/start/abort, drives instr_* etc.)
//   master : the host/testbench side (opposite directions)
// Signals:
//   prog_we/prog_addr/prog_data : store write port
//   start / abort               : run control pulses
//   instr_out / instr_valid     : instruction to CPU, valid while issued
//   pc, busy, done, halt_hit    : status
//   state                       : debug view of the FSM state register
// Handshake: there is no back-pressure. instr_valid qualifies instr_out on
// every cycle it is high; when it is low instr_out carries the NOP word.
// -----------------------------------------------------------------------------
interface instr_sequencer_if
    import instr_sequencer_pkg::*;
#(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
);
    logic                   prog_we;
    logic [PC_BITS-1:0]     prog_addr;
    logic [INSTR_WIDTH-1:0] prog_data;
    logic                   start;
    logic                   abort;

    logic [INSTR_WIDTH-1:0] instr_out;
    logic                   instr_valid;
    logic [PC_BITS-1:0]     pc;
    logic                   busy;
    logic                   done;
    logic                   halt_hit;
    logic [STATE_W-1:0]     state;

    modport slave (
        input  prog_we, prog_addr, prog_data, start, abort,
        output instr_out, instr_valid, pc, busy, done, halt_hit, state
    );

    modport master (
        output prog_we, prog_addr, prog_data, start, abort,
        input  instr_out, instr_valid, pc, busy, done, halt_hit, state
    );
endinterface

// File: rtl/instr_store.sv
// -----------------------------------------------------------------------------
// instr_store
// 2**ADDR_BITS x DATA_WIDTH instruction RAM, synchronous write, synchronous
// read with one cycle latency. A read of the address being written in the
// same cycle returns the new data (write-first).
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address (sampled every cycle)
//   rdata_o  read data, valid the cycle after raddr_i was presented
// Contents are not reset.
// -----------------------------------------------------------------------------
module instr_store #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_BITS-1:0]  waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_BITS-1:0]  raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        // Bypass the write data so a same-cycle read sees the new word.
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Program sequencer for the simple CPU. Holds a small instruction store loaded
// over a write port, then steps a program counter through it and presents each
// instruction for CYCLES_PER_INSTR cycles. A HALT opcode or the last store
// address ends the program.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  instr_sequencer_if.slave (prog write port, start/abort, instruction
//        output, pc/busy/done/halt_hit status, debug state)
// All outputs are registered.
// -----------------------------------------------------------------------------
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int                     INSTR_WIDTH      = 20,
    parameter int                     PC_BITS          = 5,
    parameter int                     CYCLES_PER_INSTR = 4,
    parameter logic [3:0]             HALT_OPC         = HALT_OPC_DEF,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR        = NOP_INSTR_DEF
) (
    input  logic                clk,
    input  logic                rst,
    instr_sequencer_if.slave    bus
);
    localparam logic [PC_BITS-1:0] PC_LAST   = '1;
    localparam logic [3:0]         HOLD_LAST = 4'(CYCLES_PER_INSTR - 1);

    logic [STATE_W-1:0]     state_q, state_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [3:0]             hold_q, hold_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   halt_q, halt_d;

    logic                   store_we;
    logic [INSTR_WIDTH-1:0] rd_data;
    logic                   rd_is_halt;

    // Writes are only honoured while no program is running.
    assign store_we   = bus.prog_we && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign rd_is_halt = (rd_data[OPC_MSB:OPC_LSB] == HALT_OPC);

    // The store is addressed with the next pc, so the word for a FETCH cycle
    // is already on rd_data during that cycle and can be registered straight
    // into instr_out at the end of it.
    instr_store #(
        .DATA_WIDTH (INSTR_WIDTH),
        .ADDR_BITS  (PC_BITS)
    ) u_store (
        .clk_i   (clk),
        .we_i    (store_we),
        .waddr_i (bus.prog_addr),
        .wdata_i (bus.prog_data),
        .raddr_i (pc_d),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        done_d  = done_q;
        halt_d  = halt_q;

        if (bus.abort) begin
            state_d = ST_IDLE;
            pc_d    = '0;
            hold_d  = '0;
            done_d  = 1'b0;
            halt_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = ST_FETCH;
                        pc_d    = '0;
                        hold_d  = '0;
                    end
                end
                ST_FETCH: begin
                    hold_d = '0;
                    if (rd_is_halt) begin
                        // HALT word is never presented to the CPU.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        instr_d = rd_data;
                        valid_d = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (pc_q == PC_LAST) begin
                            // End of store: stop without wrapping pc.
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            halt_d  = 1'b0;
                        end else begin
                            state_d = ST_FETCH;
                            pc_d    = pc_q + 1'b1;
                        end
                    end else begin
                        hold_d  = hold_q + 1'b1;
                        instr_d = instr_q;
                        valid_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.start) begin
                        state_d = ST_FETCH;
                        pc_d    = '0;
                        hold_d  = '0;
                        done_d  = 1'b0;
                        halt_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                    hold_d  = '0;
                    done_d  = 1'b0;
                    halt_d  = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == ST_FETCH) || (state_d == ST_ISSUE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            hold_q  <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            halt_q  <= halt_d;
        end
    end

    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.halt_hit    = halt_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Directed bench for instr_sequencer. dut0 uses CYCLES_PER_INSTR=4, dut1 uses
// CYCLES_PER_INSTR=1. Inputs are driven and outputs sampled 1 time unit after
// each rising clock edge.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    instr_sequencer_if #(.INSTR_WIDTH(20), .PC_BITS(5)) bus0 ();
    instr_sequencer_if #(.INSTR_WIDTH(20), .PC_BITS(5)) bus1 ();

    instr_sequencer #(.CYCLES_PER_INSTR(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    instr_sequencer #(.CYCLES_PER_INSTR(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic write0(input logic [4:0] addr, input logic [19:0] data);
        bus0.prog_we   = 1'b1;
        bus0.prog_addr = addr;
        bus0.prog_data = data;
        step();
        bus0.prog_we   = 1'b0;
    endtask

    task automatic write1(input logic [4:0] addr, input logic [19:0] data);
        bus1.prog_we   = 1'b1;
        bus1.prog_addr = addr;
        bus1.prog_data = data;
        step();
        bus1.prog_we   = 1'b0;
    endtask

    task automatic start0();
        bus0.start = 1'b1;
        step();
        bus0.start = 1'b0;
    endtask

    // checks one cycle of dut0 output: valid, instr, pc
    task automatic out0(input string tag, input logic v, input logic [19:0] ins, input logic [4:0] p);
        chk({tag, "_valid"}, 32'(bus0.instr_valid), 32'(v));
        chk({tag, "_instr"}, 32'(bus0.instr_out), 32'(ins));
        chk({tag, "_pc"}, 32'(bus0.pc), 32'(p));
    endtask

    // runs the three-word program on dut0 after a start pulse, expecting
    // word1 at pc=1, and finishing on the HALT at pc=2
    task automatic run_prog0(input string tag, input logic [19:0] w1);
        start0();
        chk({tag, "_fetch_busy"}, 32'(bus0.busy), 32'd1);
        chk({tag, "_fetch_done"}, 32'(bus0.done), 32'd0);
        out0({tag, "_fetch0"}, 1'b0, 20'h0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            out0({tag, "_i0"}, 1'b1, 20'h1A0B0, 5'd0);
        end
        step();
        out0({tag, "_nop1"}, 1'b0, 20'h0, 5'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            out0({tag, "_i1"}, 1'b1, w1, 5'd1);
        end
        step();
        out0({tag, "_nop2"}, 1'b0, 20'h0, 5'd2);
        step();
        out0({tag, "_done"}, 1'b0, 20'h0, 5'd2);
        chk({tag, "_done_flag"}, 32'(bus0.done), 32'd1);
        chk({tag, "_halt_hit"}, 32'(bus0.halt_hit), 32'd1);
        chk({tag, "_busy_done"}, 32'(bus0.busy), 32'd0);
    endtask

    initial begin
        int valid_cycles;
        int issues;
        int wraps;
        int cycles;
        logic prev_valid;
        logic [4:0] prev_pc;

        rst = 1'b0;
        bus0.prog_we = 1'b0; bus0.prog_addr = '0; bus0.prog_data = '0;
        bus0.start = 1'b0;   bus0.abort = 1'b0;
        bus1.prog_we = 1'b0; bus1.prog_addr = '0; bus1.prog_data = '0;
        bus1.start = 1'b0;   bus1.abort = 1'b0;

        // ---- reset values ----
        step();
        step();
        chk("rst_instr", 32'(bus0.instr_out), 32'h0);
        chk("rst_valid", 32'(bus0.instr_valid), 32'd0);
        chk("rst_pc", 32'(bus0.pc), 32'd0);
        chk("rst_busy", 32'(bus0.busy), 32'd0);
        chk("rst_done", 32'(bus0.done), 32'd0);
        chk("rst_halt", 32'(bus0.halt_hit), 32'd0);
        chk("rst_state", 32'(bus0.state), 32'(ST_IDLE));
        rst = 1'b1;
        step();

        // ---- normal run, with a guarded write during ISSUE ----
        write0(5'd0, 20'h1A0B0);
        write0(5'd1, 20'h2C0D0);
        write0(5'd2, 20'hF0000);
        start0();
        chk("norm_fetch_state", 32'(bus0.state), 32'(ST_FETCH));
        out0("norm_fetch0", 1'b0, 20'h0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                bus0.prog_we   = 1'b1;
                bus0.prog_addr = 5'd1;
                bus0.prog_data = 20'h77777;
            end
            step();
            bus0.prog_we = 1'b0;
            out0("norm_i0", 1'b1, 20'h1A0B0, 5'd0);
        end
        step();
        out0("norm_nop1", 1'b0, 20'h0, 5'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            out0("norm_i1", 1'b1, 20'h2C0D0, 5'd1);
        end
        step();
        out0("norm_nop2", 1'b0, 20'h0, 5'd2);
        step();
        out0("norm_done", 1'b0, 20'h0, 5'd2);
        chk("norm_done_flag", 32'(bus0.done), 32'd1);
        chk("norm_halt_hit", 32'(bus0.halt_hit), 32'd1);
        chk("norm_state", 32'(bus0.state), 32'(ST_DONE));
        step();
        out0("norm_done_hold", 1'b0, 20'h0, 5'd2);
        chk("norm_done_hold_flag", 32'(bus0.done), 32'd1);

        // ---- rerun: write during ISSUE must not have landed ----
        run_prog0("rerun", 20'h2C0D0);

        // ---- write in DONE is honoured ----
        write0(5'd1, 20'h77777);
        run_prog0("donewr", 20'h77777);
        write0(5'd1, 20'h2C0D0);

        // ---- abort with start during 3rd cycle of pc=1 ISSUE ----
        start0();
        for (int i = 0; i < 5; i++) step();
        step();
        step();
        step();
        out0("abort_pre", 1'b1, 20'h2C0D0, 5'd1);
        bus0.abort = 1'b1;
        bus0.start = 1'b1;
        step();
        bus0.abort = 1'b0;
        bus0.start = 1'b0;
        out0("abort_post", 1'b0, 20'h0, 5'd0);
        chk("abort_state", 32'(bus0.state), 32'(ST_IDLE));
        chk("abort_busy", 32'(bus0.busy), 32'd0);
        chk("abort_done", 32'(bus0.done), 32'd0);
        step();
        chk("abort_start_ignored", 32'(bus0.state), 32'(ST_IDLE));
        chk("abort_start_busy", 32'(bus0.busy), 32'd0);

        // ---- start + prog_we same cycle in IDLE: write-first ----
        bus0.prog_we   = 1'b1;
        bus0.prog_addr = 5'd0;
        bus0.prog_data = 20'h3ABCD;
        bus0.start     = 1'b1;
        step();
        bus0.prog_we = 1'b0;
        bus0.start   = 1'b0;
        step();
        out0("wfirst", 1'b1, 20'h3ABCD, 5'd0);
        bus0.abort = 1'b1;
        step();
        bus0.abort = 1'b0;
        chk("wfirst_abort_state", 32'(bus0.state), 32'(ST_IDLE));

        // ---- async reset mid-ISSUE ----
        write0(5'd0, 20'h1A0B0);
        write0(5'd1, 20'h12345);
        start0();
        for (int i = 0; i < 5; i++) step();
        step();
        out0("arst_pre", 1'b1, 20'h12345, 5'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_instr", 32'(bus0.instr_out), 32'h0);
        chk("arst_valid", 32'(bus0.instr_valid), 32'd0);
        chk("arst_pc", 32'(bus0.pc), 32'd0);
        chk("arst_busy", 32'(bus0.busy), 32'd0);
        step();
        rst = 1'b1;
        step();

        // ---- end of store: 32 words, no HALT ----
        for (int a = 0; a < 32; a++) write0(5'(a), 20'h10000);
        start0();
        valid_cycles = 0;
        issues       = 0;
        wraps        = 0;
        cycles       = 0;
        prev_valid   = 1'b0;
        prev_pc      = bus0.pc;
        while (!bus0.done && cycles < 400) begin
            step();
            cycles++;
            if (bus0.instr_valid) valid_cycles++;
            if (bus0.instr_valid && !prev_valid) issues++;
            if (bus0.pc < prev_pc) wraps++;
            prev_valid = bus0.instr_valid;
            prev_pc    = bus0.pc;
        end
        chk("eos_bounded", 32'(cycles < 400), 32'd1);
        chk("eos_valid_cycles", 32'(valid_cycles), 32'd128);
        chk("eos_issues", 32'(issues), 32'd32);
        chk("eos_no_wrap", 32'(wraps), 32'd0);
        chk("eos_done", 32'(bus0.done), 32'd1);
        chk("eos_halt_hit", 32'(bus0.halt_hit), 32'd0);
        chk("eos_pc", 32'(bus0.pc), 32'd31);
        chk("eos_valid_low", 32'(bus0.instr_valid), 32'd0);
        step();
        chk("eos_pc_hold", 32'(bus0.pc), 32'd31);

        // ---- CYCLES_PER_INSTR=1 sweep on dut1 ----
        write1(5'd0, 20'h1A0B0);
        write1(5'd1, 20'h2C0D0);
        write1(5'd2, 20'hF0000);
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        chk("cpi1_fetch_valid", 32'(bus1.instr_valid), 32'd0);
        step();
        chk("cpi1_v0", 32'(bus1.instr_valid), 32'd1);
        chk("cpi1_i0", 32'(bus1.instr_out), 32'h1A0B0);
        step();
        chk("cpi1_nop1", 32'(bus1.instr_valid), 32'd0);
        chk("cpi1_nop1_instr", 32'(bus1.instr_out), 32'h0);
        step();
        chk("cpi1_v1", 32'(bus1.instr_valid), 32'd1);
        chk("cpi1_i1", 32'(bus1.instr_out), 32'h2C0D0);
        step();
        chk("cpi1_nop2", 32'(bus1.instr_valid), 32'd0);
        chk("cpi1_nop2_done", 32'(bus1.done), 32'd0);
        step();
        chk("cpi1_done", 32'(bus1.done), 32'd1);
        chk("cpi1_halt_hit", 32'(bus1.halt_hit), 32'd1);
        chk("cpi1_pc", 32'(bus1.pc), 32'd2);
        chk("cpi1_valid_done", 32'(bus1.instr_valid), 32'd0);

        // ---- final report ----
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Program sequencer for the simple CPU. It holds a small instruction store that is loaded over a write port. It then steps a program counter through that store and presents each 20-bit instruction to the CPU's instruction input. Each instruction is held stable for a fixed number of cycles, one CPU instruction period. The block sits between the testbench/host and the CPU top level and owns all instruction timing.

Parameters:
INSTR_WIDTH, 20, instruction word width; matches CPU instruction input.
PC_BITS, 5, program counter width; store depth = 2**PC_BITS (32 words).
CYCLES_PER_INSTR, 4, cycles each instruction is held on instr_out; legal range 1..15.
HALT_OPC, 4'hF, value of instr[19:16] that terminates the program.
NOP_INSTR, 20'h00000, word driven on instr_out whenever no instruction is being issued.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
prog_we  input  1  store write enable; honoured only in IDLE or DONE.
prog_addr  input  PC_BITS  store write address.
prog_data  input  INSTR_WIDTH  store write data.
start  input  1  one-cycle pulse; begins execution at address 0.
abort  input  1  stops execution; returns to IDLE.
instr_out  output  INSTR_WIDTH  instruction to CPU.
instr_valid  output  1  high while instr_out carries a real instruction.
pc  output  PC_BITS  address of the instruction currently issued or fetched.
busy  output  1  high in FETCH and ISSUE.
done  output  1  high in DONE.
halt_hit  output  1  in DONE: 1 = stopped on HALT opcode, 0 = stopped at end of store.

Behaviour:
- Reset (rst low, async): state=IDLE, pc=0, hold counter=0, instr_out=NOP_INSTR, instr_valid=0, busy=0, done=0, halt_hit=0. Store contents are not reset.
- Store: 2**PC_BITS x INSTR_WIDTH, synchronous write, synchronous read (1-cycle latency). A prog_we arriving in FETCH or ISSUE is ignored.
- FSM states:
  - IDLE: start -> FETCH with pc=0.
  - FETCH: 1 cycle; read store[pc]. Next cycle, if data[19:16]==HALT_OPC -> DONE with halt_hit=1, and the HALT word is never issued. Otherwise -> ISSUE.
  - ISSUE: instr_out=store[pc], instr_valid=1 for exactly CYCLES_PER_INSTR cycles. On the last cycle: if pc==2**PC_BITS-1 -> DONE with halt_hit=0; else pc<=pc+1 -> FETCH. pc does not wrap.
  - DONE: holds pc. start -> FETCH with pc=0 and done/halt_hit cleared. abort -> IDLE.
- Instruction period: latency from start to first instr_valid is 2 cycles. Back-to-back instructions are separated by one FETCH cycle, during which instr_out=NOP_INSTR and instr_valid=0.
- Output rule: instr_out=NOP_INSTR whenever instr_valid=0. All outputs are registered.
- Simultaneous events:
  - abort has priority over start and over every transition. It takes effect next cycle: IDLE, instr_out=NOP_INSTR, pc=0, done=0.
  - start while busy is ignored.
  - start and prog_we in the same cycle in IDLE: the write completes and the FETCH of the same address returns the new data (write-first).
- Reset mid-ISSUE: outputs go to reset values immediately, without waiting for clk.
- CYCLES_PER_INSTR=1: every instruction is valid for 1 cycle followed by 1 NOP cycle.

Decomposition:
- Shared package: state encoding (IDLE, FETCH, ISSUE, DONE), field constants OPC_MSB=19 and OPC_LSB=16, the default HALT_OPC and NOP_INSTR.
- One natural sub-module, instr_store: the synchronous RAM with write-first read. The FSM, pc and hold counter stay in instr_sequencer.

Test Plan:
- Reset: drive rst low mid-ISSUE with instr_out=20'h12345 -> instr_out=0, instr_valid=0, pc=0, busy=0 asynchronously, before the next clk edge.
- Normal run: load addr0=20'h1A0B0, addr1=20'h2C0D0, addr2=20'hF0000, then pulse start -> 20'h1A0B0 valid for 4 cycles starting 2 cycles after start, 1 NOP cycle, 20'h2C0D0 valid for 4 cycles, 1 NOP cycle, then done=1, halt_hit=1, pc=2; 20'hF0000 never appears on instr_out.
- End of store: fill all 32 words with 20'h10000 and start -> 32 issues of 4 cycles each, done=1, halt_hit=0, pc=31, no wrap to 0.
- Abort: assert abort together with start during the 3rd cycle of the pc=1 ISSUE -> next cycle IDLE, instr_out=0, pc=0; start is ignored.
- Write guard: prog_we to addr1 with 20'h77777 during ISSUE, then rerun -> addr1 still issues 20'h2C0D0. Same write in DONE, then start -> 20'h77777 is issued.
- Parameter sweep: CYCLES_PER_INSTR=1 with the normal-run program -> valid pattern 1,0,1,0, then done.
